// File: rtl/use_stream_pkg.sv
// Shared definitions for the USE record stream elements (transmit packer and receive side).
package use_stream_pkg;

   typedef logic [7:0] byte_t;

   localparam byte_t VARIABLEFIELD_DELIMITER = 8'h2c;

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      FLUSH = 2'd1,
      DONE  = 2'd2
   } packer_state_t;

   // Largest record: variable field, one delimiter byte, fixed field.
   function automatic int use_max_bytes(input int var_len, input int fixed_len);
      return var_len + fixed_len + 1;
   endfunction

endpackage

// File: rtl/use_byte_aligner.sv
// Places the first rec_len bytes of a record at byte offset 'offset' of a DEPTH-byte vector.
module use_byte_aligner #(
   parameter int REC_BYTES = 34,
   parameter int DEPTH     = 42,
   parameter int LEN_W     = 6,
   parameter int OFF_W     = 6
)(
   input  logic [REC_BYTES*8-1:0] rec_data,
   input  logic [LEN_W-1:0]       rec_len,
   input  logic [OFF_W-1:0]       offset,
   output logic [DEPTH*8-1:0]     ins_data,
   output logic [DEPTH-1:0]       ins_mask
);

   logic [DEPTH*8-1:0] ext_s;
   logic [DEPTH-1:0]   keep_s;

   // Keep only the valid record bytes, then shift them up to the insert offset.
   always_comb begin
      ext_s  = '0;
      keep_s = '0;
      for (int k = 0; k < REC_BYTES; k++) begin
         if (LEN_W'(k) < rec_len) begin
            ext_s[k*8 +: 8] = rec_data[k*8 +: 8];
            keep_s[k]       = 1'b1;
         end else begin
            ext_s[k*8 +: 8] = 8'h00;
            keep_s[k]       = 1'b0;
         end
      end
      ins_data = ext_s << {offset, 3'b000};
      ins_mask = keep_s << offset;
   end

endmodule

// File: rtl/use_stream_packer.sv
// Packs variable-length USE records gap-free into an AXI-Stream master; flush emits the tail with TLAST.
// Optional macro USE_PACKER_STATS_EN enables the stat_records / stat_bytes counters (tied to 0 otherwise).
module use_stream_packer
   import use_stream_pkg::*;
#(
   parameter int DATA_BUS_WIDTH_BYTES     = 8,
   parameter int MAX_VARIABLEFIELD_LENGTH = 16,
   parameter int FIXEDFIELD_LENGTH_BYTES  = 32'h11,
   localparam int MAX_USE_BYTES = use_max_bytes(MAX_VARIABLEFIELD_LENGTH, FIXEDFIELD_LENGTH_BYTES),
   localparam int BUF_DEPTH     = MAX_USE_BYTES + DATA_BUS_WIDTH_BYTES,
   localparam int LEN_W         = $clog2(MAX_USE_BYTES + 1)
)(
   input  logic                              clk,
   input  logic                              reset,
   input  logic [MAX_USE_BYTES*8-1:0]        use_data,
   input  logic [LEN_W-1:0]                  use_len,
   input  logic                              use_valid,
   output logic                              use_ready,
   input  logic                              flush_req,
   output logic                              flush_done,
   output logic [DATA_BUS_WIDTH_BYTES*8-1:0] m_tdata,
   output logic [DATA_BUS_WIDTH_BYTES-1:0]   m_tkeep,
   output logic                              m_tlast,
   output logic                              m_tvalid,
   input  logic                              m_tready,
   output logic                              len_err,
   output logic [31:0]                       stat_records,
   output logic [31:0]                       stat_bytes
);

   localparam int                W      = DATA_BUS_WIDTH_BYTES;
   localparam int                FILL_W = $clog2(BUF_DEPTH + 1);
   localparam logic [FILL_W-1:0] W_F    = FILL_W'(W);
   localparam logic [LEN_W-1:0]  MAX_L  = LEN_W'(MAX_USE_BYTES);

   byte_t [BUF_DEPTH-1:0]  acc_r;
   byte_t [BUF_DEPTH-1:0]  acc_nx;
   logic [FILL_W-1:0]      fill_r;
   logic [FILL_W-1:0]      fill_nx;
   packer_state_t          state_r;
   packer_state_t          state_nx;
   logic                   in_reset_r;
   logic                   len_err_r;
   logic [LEN_W-1:0]       len_c_s;
   logic                   accept_s;
   logic                   emit_s;
   logic                   flush_pending_s;
   logic                   m_tvalid_s;
   logic                   m_tlast_s;
   logic [BUF_DEPTH*8-1:0] ins_data_s;
   logic [BUF_DEPTH-1:0]   ins_mask_s;

   assign flush_pending_s = (state_r != ACCUM);
   assign use_ready  = !in_reset_r && (fill_r < W_F) && !flush_pending_s;
   assign len_c_s    = (use_len > MAX_L) ? MAX_L : use_len;
   assign accept_s   = use_valid && use_ready;
   assign m_tvalid_s = (fill_r >= W_F) || (flush_pending_s && (fill_r != '0));
   assign m_tlast_s  = (state_r == FLUSH) && (fill_r != '0) && (fill_r <= W_F);
   assign emit_s     = m_tvalid_s && m_tready;

   assign m_tvalid   = m_tvalid_s;
   assign m_tlast    = m_tlast_s;
   assign flush_done = (state_r == DONE);
   assign len_err    = len_err_r;

   use_byte_aligner #(
      .REC_BYTES (MAX_USE_BYTES),
      .DEPTH     (BUF_DEPTH),
      .LEN_W     (LEN_W),
      .OFF_W     (FILL_W)
   ) u_aligner (
      .rec_data (use_data),
      .rec_len  (len_c_s),
      .offset   (fill_r),
      .ins_data (ins_data_s),
      .ins_mask (ins_mask_s)
   );

   // Accumulator update: merge an accepted record above fill, or drop one beat off the bottom.
   always_comb begin
      acc_nx  = acc_r;
      fill_nx = fill_r;
      if (accept_s) begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            if (ins_mask_s[i]) begin
               acc_nx[i] = ins_data_s[i*8 +: 8];
            end else begin
               acc_nx[i] = acc_r[i];
            end
         end
         fill_nx = fill_r + FILL_W'(len_c_s);
      end else if (emit_s) begin
         acc_nx  = acc_r >> (W * 8);
         fill_nx = (fill_r >= W_F) ? (fill_r - W_F) : '0;
      end else begin
         acc_nx  = acc_r;
         fill_nx = fill_r;
      end
   end

   // Flush sequencing; an empty buffer on entry skips straight to DONE.
   always_comb begin
      state_nx = state_r;
      case (state_r)
         ACCUM: begin
            if (flush_req) begin
               state_nx = FLUSH;
            end else begin
               state_nx = ACCUM;
            end
         end
         FLUSH: begin
            if (fill_r == '0) begin
               state_nx = DONE;
            end else if (emit_s && m_tlast_s) begin
               state_nx = DONE;
            end else begin
               state_nx = FLUSH;
            end
         end
         DONE:    state_nx = ACCUM;
         default: state_nx = ACCUM;
      endcase
   end

   // Output beat: bytes at or above fill are masked so stale contents never leak.
   always_comb begin
      m_tdata = '0;
      m_tkeep = '0;
      for (int i = 0; i < W; i++) begin
         if (FILL_W'(i) < fill_r) begin
            m_tdata[i*8 +: 8] = acc_r[i];
            m_tkeep[i]        = 1'b1;
         end else begin
            m_tdata[i*8 +: 8] = 8'h00;
            m_tkeep[i]        = 1'b0;
         end
      end
   end

   // Control registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         fill_r     <= '0;
         state_r    <= ACCUM;
         in_reset_r <= 1'b1;
         len_err_r  <= 1'b0;
      end else begin
         fill_r     <= fill_nx;
         state_r    <= state_nx;
         in_reset_r <= 1'b0;
         len_err_r  <= accept_s && (use_len > MAX_L);
      end
   end

   // Byte storage; contents above fill are don't-care, so no reset.
   always_ff @(posedge clk) begin
      acc_r <= acc_nx;
   end

`ifdef USE_PACKER_STATS_EN
   logic [31:0] stat_records_r;
   logic [31:0] stat_bytes_r;

   // Record and post-clamp byte counters, wrapping modulo 2**32.
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_records_r <= 32'h0;
         stat_bytes_r   <= 32'h0;
      end else if (accept_s) begin
         stat_records_r <= stat_records_r + 32'h1;
         stat_bytes_r   <= stat_bytes_r + 32'(len_c_s);
      end else begin
         stat_records_r <= stat_records_r;
         stat_bytes_r   <= stat_bytes_r;
      end
   end

   assign stat_records = stat_records_r;
   assign stat_bytes   = stat_bytes_r;
`else
   assign stat_records = 32'h0;
   assign stat_bytes   = 32'h0;
`endif

endmodule
